// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: NUM_RW read/write control registers followed by read-only status registers.
// Define REG_BANK_WR_PULSE_EN to add the per-register write-commit strobe output wr_pulse.
module axi_lite_reg_bank #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 6,
   parameter int unsigned           NUM_REGS   = 8,
   parameter int unsigned           NUM_RW     = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = {DATA_WIDTH{1'b0}}
) (
   input  logic                                 ACLK,
   input  logic                                 ARESETN,
   input  logic [ADDR_WIDTH-1:0]                S_AXI_AWADDR,
   input  logic [2:0]                           S_AXI_AWPROT,
   input  logic                                 S_AXI_AWVALID,
   output logic                                 S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]                S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
   input  logic                                 S_AXI_WVALID,
   output logic                                 S_AXI_WREADY,
   output logic [1:0]                           S_AXI_BRESP,
   output logic                                 S_AXI_BVALID,
   input  logic                                 S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]                S_AXI_ARADDR,
   input  logic [2:0]                           S_AXI_ARPROT,
   input  logic                                 S_AXI_ARVALID,
   output logic                                 S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]                S_AXI_RDATA,
   output logic [1:0]                           S_AXI_RRESP,
   output logic                                 S_AXI_RVALID,
   input  logic                                 S_AXI_RREADY,
   output logic [NUM_RW*DATA_WIDTH-1:0]         ctrl_out,
   input  logic [(NUM_REGS-NUM_RW)*DATA_WIDTH-1:0] status_in
`ifdef REG_BANK_WR_PULSE_EN
   ,
   output logic [NUM_RW-1:0]                    wr_pulse
`endif
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
   localparam int unsigned DEPTH  = 2 ** IDX_W;
   localparam logic [IDX_W:0] NUM_RW_L   = (IDX_W + 1)'(NUM_RW);
   localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // write channel state
   logic                  aw_held_r, w_held_r;
   logic [IDX_W-1:0]      aw_idx_r;
   logic [DATA_WIDTH-1:0] w_data_r;
   logic [STRB_W-1:0]     w_strb_r;
   logic                  awready_r, wready_r, bvalid_r;
   logic [1:0]            bresp_r;
   logic                  aw_acc_s, w_acc_s, b_hs_s, commit_s, wr_ok_s;
   logic                  aw_held_nx_s, w_held_nx_s, bvalid_nx_s;
   logic [IDX_W-1:0]      wr_idx_s;
   logic [DATA_WIDTH-1:0] wr_data_s;
   logic [STRB_W-1:0]     wr_strb_s;

   // read channel state
   logic                  arready_r, rvalid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;
   logic                  ar_acc_s, r_hs_s, rvalid_nx_s, rd_err_s;
   logic [IDX_W-1:0]      rd_idx_s;

   logic [DATA_WIDTH-1:0] ctrl_r [NUM_RW];
   logic [DATA_WIDTH-1:0] view_s [DEPTH];
   logic                  unused_s;

   // protection bits and sub-word address bits carry no meaning for this bank
   assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

   // Write handshakes, commit decision and next-state of the write holding flags
   always_comb begin
      aw_acc_s = S_AXI_AWVALID & awready_r;
      w_acc_s  = S_AXI_WVALID & wready_r;
      b_hs_s   = bvalid_r & S_AXI_BREADY;
      // commit on the edge that completes the AW/W pair, whichever arrives last
      commit_s = (aw_acc_s | w_acc_s) & (aw_acc_s | aw_held_r) & (w_acc_s | w_held_r);
      if (aw_acc_s) begin
         wr_idx_s = S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
      end else begin
         wr_idx_s = aw_idx_r;
      end
      if (w_acc_s) begin
         wr_data_s = S_AXI_WDATA;
         wr_strb_s = S_AXI_WSTRB;
      end else begin
         wr_data_s = w_data_r;
         wr_strb_s = w_strb_r;
      end
      wr_ok_s = ({1'b0, wr_idx_s} < NUM_RW_L);
      if (b_hs_s) begin
         aw_held_nx_s = 1'b0;
         w_held_nx_s  = 1'b0;
         bvalid_nx_s  = 1'b0;
      end else begin
         aw_held_nx_s = aw_held_r | aw_acc_s;
         w_held_nx_s  = w_held_r | w_acc_s;
         bvalid_nx_s  = bvalid_r | commit_s;
      end
   end

   // Write channel registers: holding slots, registered readies and B response
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_held_r <= 1'b0;
         w_held_r  <= 1'b0;
         aw_idx_r  <= {IDX_W{1'b0}};
         w_data_r  <= {DATA_WIDTH{1'b0}};
         w_strb_r  <= {STRB_W{1'b0}};
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
      end else begin
         aw_held_r <= aw_held_nx_s;
         w_held_r  <= w_held_nx_s;
         awready_r <= ~aw_held_nx_s & ~bvalid_nx_s;
         wready_r  <= ~w_held_nx_s & ~bvalid_nx_s;
         bvalid_r  <= bvalid_nx_s;
         if (aw_acc_s) begin
            aw_idx_r <= S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
         end
         if (w_acc_s) begin
            w_data_r <= S_AXI_WDATA;
            w_strb_r <= S_AXI_WSTRB;
         end
         if (commit_s) begin
            bresp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Control register file with byte-lane write enables
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int k = 0; k < NUM_RW; k++) begin
            ctrl_r[k] <= RESET_VAL;
         end
      end else if (commit_s && wr_ok_s) begin
         for (int k = 0; k < NUM_RW; k++) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (wr_idx_s == IDX_W'(k) && wr_strb_s[b]) begin
                  ctrl_r[k][b*8 +: 8] <= wr_data_s[b*8 +: 8];
               end
            end
         end
      end
   end

   // Flat view of the whole decoded address space; undecoded slots read as zero
   for (genvar g = 0; g < DEPTH; g++) begin : g_view
      if (g < NUM_RW) begin : g_rw
         assign view_s[g] = ctrl_r[g];
      end else if (g < NUM_REGS) begin : g_ro
         assign view_s[g] = status_in[(g-NUM_RW)*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_none
         assign view_s[g] = {DATA_WIDTH{1'b0}};
      end
   end

   for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_out
      assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_r[g];
   end

   // Read handshakes and address decode
   always_comb begin
      ar_acc_s = S_AXI_ARVALID & arready_r;
      r_hs_s   = rvalid_r & S_AXI_RREADY;
      rd_idx_s = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
      rd_err_s = ({1'b0, rd_idx_s} >= NUM_REGS_L);
      if (ar_acc_s) begin
         rvalid_nx_s = 1'b1;
      end else if (r_hs_s) begin
         rvalid_nx_s = 1'b0;
      end else begin
         rvalid_nx_s = rvalid_r;
      end
   end

   // Read channel registers; data captured from pre-write register state on accept
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= {DATA_WIDTH{1'b0}};
         rresp_r   <= RESP_OKAY;
      end else begin
         arready_r <= ~rvalid_nx_s;
         rvalid_r  <= rvalid_nx_s;
         if (ar_acc_s) begin
            rdata_r <= rd_err_s ? {DATA_WIDTH{1'b0}} : view_s[rd_idx_s];
            rresp_r <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

`ifdef REG_BANK_WR_PULSE_EN
   logic [NUM_RW-1:0] wr_pulse_r;

   // One-cycle strobe aligned with the first cycle of the newly committed value
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_pulse_r <= {NUM_RW{1'b0}};
      end else begin
         for (int k = 0; k < NUM_RW; k++) begin
            wr_pulse_r[k] <= commit_s & wr_ok_s & (wr_idx_s == IDX_W'(k));
         end
      end
   end

   assign wr_pulse = wr_pulse_r;
`endif

   assign S_AXI_AWREADY = awready_r;
   assign S_AXI_WREADY  = wready_r;
   assign S_AXI_BVALID  = bvalid_r;
   assign S_AXI_BRESP   = bresp_r;
   assign S_AXI_ARREADY = arready_r;
   assign S_AXI_RVALID  = rvalid_r;
   assign S_AXI_RDATA   = rdata_r;
   assign S_AXI_RRESP   = rresp_r;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank (32/6/8/4) against an array-based register model.
// Exercises wr_pulse as well when REG_BANK_WR_PULSE_EN is defined.
module tb_axi_lite_reg_bank;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [5:0]   awaddr = 6'h00;
   logic [2:0]   awprot = 3'b000;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [31:0]  wdata = 32'h0;
   logic [3:0]   wstrb = 4'h0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b1;
   logic [5:0]   araddr = 6'h00;
   logic [2:0]   arprot = 3'b000;
   logic         arvalid = 1'b0;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready = 1'b1;
   logic [127:0] ctrl_out;
   logic [127:0] status_in;
`ifdef REG_BANK_WR_PULSE_EN
   logic [3:0]   wr_pulse;
   int           pulse_cnt [4];
   logic [31:0]  pulse_val [4];
   logic         pulse_bv  [4];
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] m_ctrl [4];
   logic [31:0] m_status [4];

   assign status_in = {m_status[3], m_status[2], m_status[1], m_status[0]};

   always #5 clk = ~clk;

   axi_lite_reg_bank dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .ctrl_out(ctrl_out), .status_in(status_in)
`ifdef REG_BANK_WR_PULSE_EN
      , .wr_pulse(wr_pulse)
`endif
   );

`ifdef REG_BANK_WR_PULSE_EN
   // record every cycle a pulse bit is high, with the register value and BVALID seen then
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (wr_pulse[k] === 1'b1) begin
            pulse_cnt[k] = pulse_cnt[k] + 1;
            pulse_val[k] = ctrl_out[k*32 +: 32];
            pulse_bv[k]  = bvalid;
         end
      end
   end
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [1:0] model_write(input logic [5:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      int idx;
      idx = int'(addr[5:2]);
      if (idx < 4) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) m_ctrl[idx][8*b +: 8] = data[8*b +: 8];
         end
         return 2'b00;
      end
      return 2'b10;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [5:0] addr);
      int idx;
      idx = int'(addr[5:2]);
      if (idx < 4) return m_ctrl[idx];
      if (idx < 8) return m_status[idx-4];
      return 32'h0;
   endfunction

   function automatic logic [1:0] model_rresp(input logic [5:0] addr);
      return (int'(addr[5:2]) < 8) ? 2'b00 : 2'b10;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_ctrl[k] = 32'h0;
   endtask

   // ---------------- bus tasks ----------------
   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
      bit aw_done, w_done, fire_aw, fire_w;
      int cyc;
      aw_done = 1'b0; w_done = 1'b0; resp = 2'b11;
      awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom_range(0, 7)); bready = 1'b1;
      cyc = 0;
      while (!(aw_done && w_done) && cyc < 50) begin
         if (!aw_done) awvalid = (cyc >= aw_dly);
         if (!w_done)  wvalid  = (cyc >= w_dly);
         fire_aw = awvalid && awready;
         fire_w  = wvalid && wready;
         @(negedge clk);
         cyc++;
         if (fire_aw) begin aw_done = 1'b1; awvalid = 1'b0; end
         if (fire_w)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      end
      cyc = 0;
      while (bvalid !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (bvalid !== 1'b1) begin
         errors++;
         $display("FAIL write_timeout: addr=%h bvalid=%b required 1", addr, bvalid);
      end else begin
         resp = bresp;
         @(negedge clk);
      end
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] addr, input int ar_dly, output logic [31:0] data,
                           output logic [1:0] resp);
      int cyc;
      data = 32'h0; resp = 2'b11;
      araddr = addr; arprot = 3'($urandom_range(0, 7)); rready = 1'b1;
      repeat (ar_dly) @(negedge clk);
      arvalid = 1'b1;
      cyc = 0;
      while (arready !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      arvalid = 1'b0;
      while (rvalid !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (rvalid !== 1'b1) begin
         errors++;
         $display("FAIL read_timeout: addr=%h rvalid=%b required 1", addr, rvalid);
      end else begin
         data = rdata;
         resp = rresp;
         @(negedge clk);
      end
   endtask

   task automatic check_ctrl(input string name);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (ctrl_out[k*32 +: 32] !== m_ctrl[k]) begin
            errors++;
            $display("FAIL %s ctrl_out[%0d]: got %h required %h", name, k, ctrl_out[k*32 +: 32], m_ctrl[k]);
         end
      end
   endtask

   task automatic do_write(input string name, input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
      logic [1:0] resp, exp;
      exp = model_write(addr, data, strb);
      axi_write(addr, data, strb, aw_dly, w_dly, resp);
      checks++;
      if (resp !== exp) begin
         errors++;
         $display("FAIL %s bresp addr=%h: got %b required %b", name, addr, resp, exp);
      end
      check_ctrl(name);
   endtask

   task automatic do_read(input string name, input logic [5:0] addr, input int ar_dly);
      logic [31:0] d;
      logic [1:0]  resp;
      axi_read(addr, ar_dly, d, resp);
      checks++;
      if (d !== model_rdata(addr) || resp !== model_rresp(addr)) begin
         errors++;
         $display("FAIL %s read addr=%h: got %h/%b required %h/%b", name, addr, d, resp,
                  model_rdata(addr), model_rresp(addr));
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b br=%b rr=%b rdata=%h required all 0",
                  awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
      end
      check_ctrl("reset");
`ifdef REG_BANK_WR_PULSE_EN
      checks++;
      if (wr_pulse !== 4'b0000) begin
         errors++;
         $display("FAIL reset_wr_pulse: got %b required 0000", wr_pulse);
      end
`endif
      rst_n = 1'b1;
      #1;
      checks++;
      if ({awready, wready, arready} !== 3'b000) begin
         errors++;
         $display("FAIL ready_before_edge: got %b required 000", {awready, wready, arready});
      end
      @(negedge clk);
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL ready_after_edge: got %b required 111", {awready, wready, arready});
      end
   endtask

   task automatic test_basic();
      for (int k = 0; k < 4; k++) do_write("basic_wr", 6'(4*k), 32'(k+1), 4'hF, 0, 0);
      for (int k = 0; k < 4; k++) do_read("basic_rd", 6'(4*k), 0);
   endtask

   task automatic test_order();
      logic [31:0] d;
      logic [1:0]  exp;
      d = $urandom;
      // W leads AW by three cycles; BREADY held low once the response is up
      bready = 1'b0;
      awaddr = 6'h0C; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      checks++;
      if (wready !== 1'b0 || bvalid !== 1'b0) begin
         errors++;
         $display("FAIL w_only_hold: wready=%b bvalid=%b required 0 0", wready, bvalid);
      end
      repeat (2) @(negedge clk);
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      exp = model_write(6'h0C, d, 4'hF);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bvalid !== 1'b1 || bresp !== exp || awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL bresp_hold cyc%0d: bv=%b br=%b awr=%b wr=%b required 1 %b 0 0",
                     i, bvalid, bresp, awready, wready, exp);
         end
         // offer a competing write that must not be taken
         awaddr = 6'h00; wdata = 32'hFFFF_FFFF; awvalid = 1'b1; wvalid = 1'b1;
         @(negedge clk);
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
         errors++;
         $display("FAIL b_release: bv=%b awr=%b wr=%b required 0 1 1", bvalid, awready, wready);
      end
      check_ctrl("w_first");
      do_write("aw_first", 6'h08, $urandom, 4'hF, 0, 3);
      do_write("aw_w_same", 6'h04, $urandom, 4'hF, 0, 0);
   endtask

   task automatic test_strobe();
      do_write("strb_init", 6'h00, 32'hAABB_CCDD, 4'hF, 0, 0);
      do_write("strb_0101", 6'h00, 32'h1122_3344, 4'b0101, 0, 0);
      checks++;
      if (m_ctrl[0] !== 32'hAA22_CC44) begin
         errors++;
         $display("FAIL strb_model: got %h required aa22cc44", m_ctrl[0]);
      end
      do_read("strb_rd", 6'h00, 0);
      do_write("strb_zero", 6'h00, 32'h5555_5555, 4'h0, 1, 0);
      do_write("unaligned", 6'h07, 32'hCAFE_F00D, 4'hF, 0, 0);
   endtask

   task automatic test_errors();
      do_write("wr_ro", 6'h10, 32'h1234_5678, 4'hF, 0, 0);
      do_write("wr_undec", 6'h3C, 32'h8765_4321, 4'hF, 0, 0);
      do_read("rd_undec", 6'h3C, 0);
      m_status[1] = 32'hDEAD_BEEF;
      do_read("rd_status", 6'h14, 0);
   endtask

   task automatic test_same_edge();
      do_write("same_init", 6'h04, 32'h5, 4'hF, 0, 0);
      araddr = 6'h04; awaddr = 6'h04; wdata = 32'h9; wstrb = 4'hF;
      rready = 1'b0; bready = 1'b1;
      arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rvalid !== 1'b1 || rdata !== 32'h5 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL same_edge_rd cyc%0d: rv=%b rdata=%h rr=%b required 1 00000005 00",
                     i, rvalid, rdata, rresp);
         end
         @(negedge clk);
      end
      void'(model_write(6'h04, 32'h9, 4'hF));
      rready = 1'b1;
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
         errors++;
         $display("FAIL same_edge_done: rv=%b bv=%b required 0 0", rvalid, bvalid);
      end
      check_ctrl("same_edge");
      do_read("same_edge_new", 6'h04, 0);
   endtask

   task automatic test_random();
      logic [5:0] addr;
      for (int i = 0; i < 60; i++) begin
         addr = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            do_write("rand_wr", addr, $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end else begin
            for (int j = 0; j < 4; j++) m_status[j] = $urandom;
            do_read("rand_rd", addr, int'($urandom_range(0, 2)));
         end
      end
   endtask

   task automatic test_reset_mid();
      bready = 1'b0;
      awaddr = 6'h08; wdata = 32'h7777_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_bvalid: got %b required 1", bvalid);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: bv=%b awr=%b required 0 0", bvalid, awready);
      end
      check_ctrl("mid_reset");
      bready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL mid_recover: got %b required 111", {awready, wready, arready});
      end
      do_read("mid_rd", 6'h08, 0);
   endtask

`ifdef REG_BANK_WR_PULSE_EN
   task automatic pulse_step(input string name, input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
      int before [4];
      logic [3:0] exp_bits, got_bits;
      for (int k = 0; k < 4; k++) before[k] = pulse_cnt[k];
      exp_bits = 4'b0000;
      if (int'(addr[5:2]) < 4) exp_bits[addr[3:2]] = 1'b1;
      do_write(name, addr, data, strb, 0, 0);
      @(negedge clk);
      got_bits = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         got_bits[k] = (pulse_cnt[k] - before[k]) != 0;
         checks++;
         if (pulse_cnt[k] - before[k] > 1) begin
            errors++;
            $display("FAIL %s pulse_len[%0d]: got %0d cycles required 1", name, k, pulse_cnt[k] - before[k]);
         end
      end
      checks++;
      if (got_bits !== exp_bits) begin
         errors++;
         $display("FAIL %s wr_pulse: got %b required %b", name, got_bits, exp_bits);
      end
      if (exp_bits != 4'b0000) begin
         checks++;
         if (pulse_val[addr[3:2]] !== m_ctrl[addr[3:2]] || pulse_bv[addr[3:2]] !== 1'b1) begin
            errors++;
            $display("FAIL %s pulse_align: val=%h bv=%b required %h 1", name, pulse_val[addr[3:2]],
                     pulse_bv[addr[3:2]], m_ctrl[addr[3:2]]);
         end
      end
   endtask

   task automatic test_wr_pulse();
      pulse_step("pulse_reg2", 6'h08, 32'h0BAD_CAFE, 4'hF);
      pulse_step("pulse_strb0", 6'h08, 32'h1111_1111, 4'h0);
      pulse_step("pulse_ro", 6'h18, 32'h2222_2222, 4'hF);
      pulse_step("pulse_reg0", 6'h00, 32'h3333_3333, 4'b0011);
   endtask
`endif

   initial begin
      model_reset();
      for (int j = 0; j < 4; j++) m_status[j] = 32'h0;
`ifdef REG_BANK_WR_PULSE_EN
      for (int k = 0; k < 4; k++) begin
         pulse_cnt[k] = 0;
         pulse_val[k] = 32'h0;
         pulse_bv[k]  = 1'b0;
      end
`endif
      test_reset();
      test_basic();
      test_order();
      test_strobe();
      test_errors();
      test_same_edge();
      test_random();
      test_reset_mid();
`ifdef REG_BANK_WR_PULSE_EN
      test_wr_pulse();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
